// File: rtl/lsu_pkg.sv
// Shared types and memory geometry for the load/store controller.
package lsu_pkg;

  localparam int MEM_AW = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// CPU request/response and data-memory signals of the load/store controller.
interface lsu_ctrl_if;
  import lsu_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [31:0]       req_addr_i;
  logic [31:0]       req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_wren_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_addr_o, mem_wdata_o, mem_wren_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output rsp_ready_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_addr_o, mem_wdata_o, mem_wren_o
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: load extract/extend and store lane insert.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ld_data,
  input  logic [31:0] st_old,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = ld_word[{addr_lo, 3'b000} +: 8];
    half_v  = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (size)
      SZ_BYTE: ld_data = {{24{~uns & byte_v[7]}}, byte_v};
      SZ_HALF: ld_data = {{16{~uns & half_v[15]}}, half_v};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_word = st_old;
    case (size)
      SZ_BYTE: st_word[{addr_lo, 3'b000} +: 8] = st_wdata[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) st_word[31:16] = st_wdata[15:0];
        else            st_word[15:0]  = st_wdata[15:0];
      end
      default: st_word = st_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: byte/half/word CPU accesses onto a word-wide single-port memory.
// Define LSU_CTRL_MISALIGN_CHK_EN to reject misaligned half/word accesses.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  lsu_ctrl_if.slave  bus
);

  lsu_state_e        state_q, state_d;
  logic              ready_c;
  logic              req_err;
  logic              misalign;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        lo_q;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       ld_data;
  logic [31:0]       st_word;

`ifdef LSU_CTRL_MISALIGN_CHK_EN
  assign misalign = ((bus.req_size_i == SZ_HALF) && bus.req_addr_i[0]) ||
                    ((bus.req_size_i == SZ_WORD) && (bus.req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (bus.req_size_i == 2'b11) || (|bus.req_addr_i[31:12]) || misalign;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    ready_c         = 1'b0;
    bus.rsp_valid_o = 1'b0;
    bus.mem_wren_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid_i) begin
          if (req_err)                      state_d = ST_RESP;
          else if (!bus.req_we_i)           state_d = ST_LOAD;
          else if (bus.req_size_i == SZ_WORD) state_d = ST_WRITE;
          else                              state_d = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_WRITE;
      ST_WRITE: begin
        bus.mem_wren_o = 1'b1;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Visible outputs reset with the controller; rdata is cleared on accept so stores/errors return 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.req_valid_i) begin
          addr_q  <= bus.req_addr_i[11:2];
          wdata_q <= bus.req_wdata_i;
          rdata_q <= '0;
          err_q   <= req_err;
        end
        ST_LOAD:   rdata_q <= ld_data;
        ST_RMW_RD: wdata_q <= st_word;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == ST_IDLE && bus.req_valid_i) begin
      size_q <= bus.req_size_i;
      uns_q  <= bus.req_unsigned_i;
      lo_q   <= bus.req_addr_i[1:0];
    end
  end

  lsu_align u_align (
    .ld_word  (bus.mem_rdata_i),
    .addr_lo  (lo_q),
    .size     (size_q),
    .uns      (uns_q),
    .ld_data  (ld_data),
    .st_old   (bus.mem_rdata_i),
    .st_wdata (wdata_q),
    .st_word  (st_word)
  );

  assign bus.req_ready_o = ready_c & rst_ni;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a transaction-level reference model and memory.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();

  lsu_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  assign bus.mem_rdata_i = mem[bus.mem_addr_o];
  always @(posedge clk) if (bus.mem_wren_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  // Expected behaviour of the transaction currently in flight
  int          cyc = 0;
  int          acc_cyc = 0;
  int          e_lat = 0;
  bit          active = 1'b0;
  bit          done = 1'b0;
  bit          pause = 1'b1;
  bit          prev_exp_valid = 1'b0;
  bit          e_store = 1'b0;
  bit          e_err = 1'b0;
  logic [31:0] e_rdata = '0;
  logic [31:0] e_wword = '0;
  logic [9:0]  e_waddr = '0;
  logic [9:0]  last_addr = '0;

  function automatic void model(input bit we, input logic [1:0] sz, input bit uns,
                                input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w, v, mask;
    int sh;
    e_err = (sz == 2'b11) || (a[31:12] != 20'd0);
`ifdef LSU_CTRL_MISALIGN_CHK_EN
    if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) e_err = 1'b1;
`endif
    e_store = we;
    e_waddr = a[11:2];
    e_rdata = '0;
    e_wword = '0;
    w = ref_mem[a[11:2]];
    if (e_err) e_lat = 1;
    else if (!we) begin
      e_lat = 2;
      if (sz == 2'b00) begin
        v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else v = w;
      e_rdata = v;
    end else begin
      if (sz == 2'b10) begin
        e_lat = 2;
        e_wword = wd;
      end else begin
        e_lat = 3;
        sh = (sz == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        e_wword = (w & ~mask) | ((wd << sh) & mask);
      end
      ref_mem[a[11:2]] = e_wword;
    end
  endfunction

  initial begin : compare
    int d;
    bit ev, ew;
    forever begin
      @(posedge clk);
      cyc++;
      if (prev_exp_valid && bus.rsp_ready_i) done = 1'b1;
      #1;
      if (pause) prev_exp_valid = 1'b0;
      else if (active && !done) begin
        d  = cyc - acc_cyc + 1;
        ev = (d >= e_lat);
        ew = e_store && !e_err && (d == e_lat - 1);
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(ev));
        chk("req_ready_busy", 32'(bus.req_ready_o), 32'd0);
        chk("mem_wren", 32'(bus.mem_wren_o), 32'(ew));
        if (ew) begin
          chk("wr_addr", 32'(bus.mem_addr_o), 32'(e_waddr));
          chk("wr_data", bus.mem_wdata_o, e_wword);
        end
        if (!e_store && !e_err && d == 1) chk("ld_addr", 32'(bus.mem_addr_o), 32'(e_waddr));
        if (ev) begin
          chk("rsp_rdata", bus.rsp_rdata_o, e_rdata);
          chk("rsp_err", 32'(bus.rsp_err_o), 32'(e_err));
        end
        prev_exp_valid = ev;
      end else begin
        chk("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
        chk("rsp_valid_idle", 32'(bus.rsp_valid_o), 32'd0);
        chk("mem_wren_idle", 32'(bus.mem_wren_o), 32'd0);
        chk("mem_addr_hold", 32'(bus.mem_addr_o), 32'(last_addr));
        prev_exp_valid = 1'b0;
      end
    end
  end

  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] got_rd, output logic got_err);
    int n;
    got_rd = 'x;
    got_err = 1'bx;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready_o && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready_o) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    model(we, sz, uns, a, wd);
    last_addr          = a[11:2];
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = a;
    bus.req_wdata_i    = wd;
    acc_cyc = cyc + 1;
    done    = 1'b0;
    active  = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_wdata_i = $urandom;
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin @(negedge clk); n++; end
    if (!bus.rsp_valid_o) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      active = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    got_rd  = bus.rsp_rdata_o;
    got_err = bus.rsp_err_o;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    active = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_mem_wren", 32'(bus.mem_wren_o), 32'd0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd, v, old;
    logic        er;
    bit          we;
    logic [1:0]  sz;
    logic [31:0] a;
    bus.req_valid_i = 1'b0;
    bus.req_we_i = 1'b0;
    bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = '0;
    bus.req_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    pause = 1'b0;

    do_req(1'b1, 2'b10, 1'b0, 32'h040, 32'hDEAD_BEEF, 0, rd, er);
    do_req(1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEAD_BEEF);
    chk("lw_err", 32'(er), 32'd0);
    chk("mem16_deadbeef", mem[16], 32'hDEAD_BEEF);

    do_req(1'b1, 2'b10, 1'b0, 32'h040, 32'h1122_3344, 0, rd, er);
    do_req(1'b1, 2'b00, 1'b0, 32'h041, 32'h0000_00A5, 0, rd, er);
    chk("sb_merge", mem[16], 32'h1122_A544);
    chk("sb_rdata", rd, 32'h0);

    do_req(1'b0, 2'b00, 1'b0, 32'h041, 32'h0, 0, rd, er);
    chk("lb_signed", rd, 32'hFFFF_FFA5);
    do_req(1'b0, 2'b00, 1'b1, 32'h041, 32'h0, 1, rd, er);
    chk("lbu", rd, 32'h0000_00A5);
    do_req(1'b0, 2'b01, 1'b0, 32'h042, 32'h0, 0, rd, er);
    chk("lh_0x42", rd, 32'h0000_1122);

    do_req(1'b0, 2'b01, 1'b0, 32'h043, 32'h0, 0, rd, er);
`ifdef LSU_CTRL_MISALIGN_CHK_EN
    chk("lh_0x43_err", 32'(er), 32'd1);
    chk("lh_0x43_rdata", rd, 32'h0);
`else
    chk("lh_0x43_err", 32'(er), 32'd0);
    chk("lh_0x43_rdata", rd, 32'h0000_1122);
`endif

    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0, rd, er);
    chk("range_err", 32'(er), 32'd1);
    chk("range_rdata", rd, 32'h0);
    do_req(1'b1, 2'b11, 1'b0, 32'h040, 32'hFFFF_FFFF, 0, rd, er);
    chk("size11_err", 32'(er), 32'd1);
    chk("size11_nowrite", mem[16], 32'h1122_A544);

    do_req(1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 3, rd, er);
    chk("backpressure_rdata", rd, 32'h1122_A544);

    // Reset while the controller is in WRITE: the write must be dropped.
    @(negedge clk);
    old = mem[16];
    pause = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_we_i = 1'b1;
    bus.req_size_i = 2'b10;
    bus.req_addr_i = 32'h040;
    bus.req_wdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("write_state_wren", 32'(bus.mem_wren_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    chk("reset_mem_unchanged", mem[16], old);
    @(negedge clk);
    rst_n = 1'b1;
    last_addr = '0;
    active = 1'b0;
    done = 1'b0;
    pause = 1'b0;

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 15) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      do_req(we, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), rd, er);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) chk("final_mem", mem[i], ref_mem[i]);
    end
    chk("final_mem_word16", mem[16], ref_mem[16]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller that drives the single-port data memory (10-bit word address, 32-bit data, combinational read, write on clock edge) from the CPU's byte-addressed load/store requests. It sits between the execute stage and the data memory. It converts byte, halfword and word accesses into word accesses, performing read-modify-write for sub-word stores. Load results are sign- or zero-extended.

## Interface
- No parameters. Memory geometry is fixed by package constants.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  CPU request valid.
- req_ready_o  out  1  controller can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  zero-extend the load result when 1.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  CPU accepts the response.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  the access was rejected.
- mem_addr_o  out  10  word address to the memory.
- mem_wdata_o  out  32  write word to the memory.
- mem_wren_o  out  1  memory write enable.
- mem_rdata_i  in  32  memory read word; valid in the same cycle as mem_addr_o.

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready_o=1. When req_valid_i is high, latch we, size, unsigned, addr and wdata.
  - Error (size 11, addr[31:12]≠0, or misaligned when checking is enabled) → RESP with err=1.
  - Load → LOAD.
  - Word store → WRITE.
  - Byte or half store → RMW_RD.
- LOAD: mem_addr_o = addr[11:2]. Select the lane from mem_rdata_i (byte lane addr[1:0], half lane addr[1]), extend it, and register it into rsp_rdata_o. → RESP.
- RMW_RD: register mem_rdata_i with the store data inserted into the addressed lane. → WRITE.
- WRITE: mem_wren_o=1 for exactly this cycle. mem_wdata_o is the merged word, or req_wdata for a word store. → RESP.
- RESP: rsp_valid_o=1, held with rsp_rdata_o and rsp_err_o stable until rsp_ready_i. → IDLE in the cycle after the handshake.
- mem_wren_o is decoded only from state == WRITE and is never high in any other state. Errored requests never touch memory.
- mem_addr_o holds the last latched word address between accesses.
- Reset values: req_ready_o=0 while rst_ni is low, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wren_o=0, state=IDLE.
- Reset asserted mid-operation: all outputs return to their reset values immediately and asynchronously, including mem_wren_o. A pending write is dropped. No response is produced.

## Timing
- Latency is counted from the acceptance edge to the first cycle rsp_valid_o is high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Throughput is one outstanding request. req_ready_o is low in every state except IDLE.
- The earliest next acceptance is the cycle after the RESP handshake.

## Configuration
- LSU_CTRL_MISALIGN_CHK_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, sets rsp_err_o=1 with no memory access.
- Undefined: misaligned low address bits are ignored. Half uses addr[1]; word uses addr[1:0]=00. No misalignment error is raised.

## Structure
- Package lsu_pkg contains:
  - lsu_size_e with SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - lsu_state_e.
  - MEM_AW=10.
- Sub-module lsu_align, purely combinational:
  - load lane extract and extend: inputs word, addr[1:0], size, unsigned.
  - store lane insert: inputs old word, wdata, addr[1:0], size.

## Test plan
- Word store 0xDEADBEEF to 0x040, then word load from 0x040 → rsp_rdata_o=0xDEADBEEF, err=0. Both responses appear 2 cycles after acceptance. Memory word 0x010 is written.
- Memory word 0x010 = 0x11223344; byte store 0x000000A5 to 0x041 → mem_wren_o high exactly one cycle (2nd cycle after acceptance) with mem_wdata_o=0x1122A544. Response 3 cycles after acceptance.
- On word 0x1122A544:
  - Signed byte load from 0x041 → 0xFFFFFFA5.
  - Unsigned byte load from 0x041 → 0x000000A5.
  - Signed half load from 0x042 → 0x00001122.
- Half load from 0x043:
  - With the macro → err=1, rdata=0, mem_wren_o never high.
  - Without the macro → same data as 0x042.
- Load from 0x1000, and any access with size 11 → err=1 after 1 cycle, no memory write.
- Response backpressure: rsp_ready_i low for 3 cycles → rsp_valid_o and rsp_rdata_o held stable and req_ready_o=0 throughout.
- Reset in WRITE: rst_ni low in the WRITE state → mem_wren_o falls before the next edge and memory is unchanged. req_ready_o=1 in the first cycle after release.
